if_fetch_unit: RTL and testbench

- Instruction fetch stage of the 16-bit pipelined MIPS: owns the PC, issues requests to instruction memory, and fills the IF/ID pipeline register that the decode-stage control unit reads.
- It is the producer end of the IF/ID interface. It honours stall from the hazard logic and redirects from branch/jump resolution.
- A flushed or empty slot always presents instruction 16'h0000, which decode treats as a bubble (all control signals 0).

---
 rtl/if_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage of the 16-bit pipelined MIPS.
// Owns the PC, issues single outstanding requests to instruction memory,
// and fills the IF/ID register read by decode. Empty and flushed slots
// hold NOP_INSTR (16'h0000), which decode treats as a bubble.
//
// Optional feature macro: FETCH_JUMP_PREDECODE_EN
//   When this macro is defined, a captured instruction with opcode 3'd7 (jump)
//   steers the PC straight to its target instead of PC+2.
//   In the default build (macro undefined), the PC always advances by 2, and
//   jumps are resolved only through redirect.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pcplus2,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetchState;

    fetchState   state;
    logic [15:0] pc;
    logic [15:0] skidData;

    logic [15:0] pcPlus2;
    logic [15:0] redirectTarget;
    logic [15:0] captureWord;
    logic [15:0] seqNextPc;
    logic        unusedRedirectBit;

    // Bit 0 of the redirect target is forced to 0, so it is never read.
    assign unusedRedirectBit = redirect_pc[0];

    // PC arithmetic wraps modulo 2^16 by virtue of the 16-bit width.
    assign pcPlus2        = pc + 16'd2;
    assign redirectTarget = {redirect_pc[15:1], 1'b0};

    // The word loaded into IF/ID comes from memory in S_REQ or from the skid buffer in S_HOLD.
    assign captureWord = (state == S_HOLD) ? skidData : imem_data;

`ifdef FETCH_JUMP_PREDECODE_EN
    // Jump predecode: opcode 7 redirects fetch to the region-relative target.
    assign seqNextPc = (captureWord[15:13] == 3'd7)
                     ? {pcPlus2[15:14], captureWord[12:0], 1'b0}
                     : pcPlus2;
`else
    assign seqNextPc = pcPlus2;
`endif

    // Fetch FSM: PC, memory request, skid buffer and IF/ID register, all registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            skidData     <= NOP_INSTR;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            ifid_instr   <= NOP_INSTR;
            ifid_pcplus2 <= 16'h0000;
            ifid_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Any memory response here belongs to a pre-reset request and is ignored.
                    if (redirect) begin
                        pc         <= redirectTarget;
                        imem_addr  <= redirectTarget;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        skidData   <= NOP_INSTR;
                    end else begin
                        imem_addr  <= pc;
                    end
                    imem_req <= 1'b1;
                    state    <= S_REQ;
                end

                S_REQ: begin
                    if (redirect) begin
                        pc         <= redirectTarget;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        skidData   <= NOP_INSTR;
                        if (imem_valid) begin
                            // Returned data is for the wrong path; start at the target now.
                            imem_addr <= redirectTarget;
                            state     <= S_REQ;
                        end else begin
                            // Request still in flight: keep it stable and discard its data later.
                            state     <= S_DROP;
                        end
                    end else if (imem_valid) begin
                        if (stall) begin
                            skidData <= imem_data;
                            imem_req <= 1'b0;
                            state    <= S_HOLD;
                        end else begin
                            ifid_instr   <= captureWord;
                            ifid_pcplus2 <= pcPlus2;
                            ifid_valid   <= 1'b1;
                            pc           <= seqNextPc;
                            imem_addr    <= seqNextPc;
                        end
                    end
                end

                S_DROP: begin
                    // imem_addr keeps the old address until the stale response arrives.
                    if (redirect) begin
                        pc         <= redirectTarget;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        skidData   <= NOP_INSTR;
                    end
                    if (imem_valid) begin
                        imem_addr <= redirect ? redirectTarget : pc;
                        state     <= S_REQ;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc         <= redirectTarget;
                        imem_addr  <= redirectTarget;
                        imem_req   <= 1'b1;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        skidData   <= NOP_INSTR;
                        state      <= S_REQ;
                    end else if (!stall) begin
                        ifid_instr   <= captureWord;
                        ifid_pcplus2 <= pcPlus2;
                        ifid_valid   <= 1'b1;
                        pc           <= seqNextPc;
                        imem_addr    <= seqNextPc;
                        imem_req     <= 1'b1;
                        skidData     <= NOP_INSTR;
                        state        <= S_REQ;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with a behavioural
// instruction memory of programmable latency (one request in flight).
module tb_if_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pcplus2;
    logic        ifid_valid;

    int checks   = 0;
    int failures = 0;

    logic [15:0] memImg [0:32767];
    int          memLatency;
    logic        memPending;
    int          memCnt;
    logic [15:0] memAddr;

    if_fetch_unit #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .ifid_instr  (ifid_instr),
        .ifid_pcplus2(ifid_pcplus2),
        .ifid_valid  (ifid_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: accepts a request on an edge, returns data memLatency edges later
    // for one cycle; the cycle in which data is consumed never accepts a new request.
    always @(posedge clock) begin
        if (!reset) begin
            imem_valid <= 1'b0;
            memPending <= 1'b0;
            memCnt     <= 0;
        end else if (imem_valid) begin
            imem_valid <= 1'b0;
            memPending <= 1'b0;
        end else if (memPending) begin
            if (memCnt <= 1) begin
                imem_valid <= 1'b1;
                imem_data  <= memImg[memAddr[15:1]];
            end else begin
                memCnt <= memCnt - 1;
            end
        end else if (imem_req) begin
            memPending <= 1'b1;
            memAddr    <= imem_addr;
            if (memLatency <= 1) begin
                imem_valid <= 1'b1;
                imem_data  <= memImg[imem_addr[15:1]];
            end else begin
                memCnt <= memLatency - 1;
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || ifid_instr !== 16'h0000 ||
            ifid_pcplus2 !== 16'h0000 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got req=%b addr=%h instr=%h pc2=%h v=%b exp 0/0000/0000/0000/0",
                     imem_req, imem_addr, ifid_instr, ifid_pcplus2, ifid_valid);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_req got req=%b addr=%h v=%b exp 1/0000/0", imem_req, imem_addr, ifid_valid);
        end
        $display("tb: reset released, first request at %h", imem_addr);
    endtask

    task automatic test_fetch();
        tick(2);
        checks++;
        if (ifid_instr !== 16'h0001 || ifid_pcplus2 !== 16'h0002 || ifid_valid !== 1'b1 || imem_addr !== 16'h0002) begin
            failures++;
            $display("FAIL fetch0 got instr=%h pc2=%h v=%b addr=%h exp 0001/0002/1/0002",
                     ifid_instr, ifid_pcplus2, ifid_valid, imem_addr);
        end
        $display("tb: fetched %h pc2=%h", ifid_instr, ifid_pcplus2);
        tick(2);
        checks++;
        if (ifid_instr !== 16'h2002 || ifid_pcplus2 !== 16'h0004 || ifid_valid !== 1'b1 || imem_addr !== 16'h0004) begin
            failures++;
            $display("FAIL fetch2 got instr=%h pc2=%h v=%b addr=%h exp 2002/0004/1/0004",
                     ifid_instr, ifid_pcplus2, ifid_valid, imem_addr);
        end
        $display("tb: fetched %h pc2=%h", ifid_instr, ifid_pcplus2);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick(1);
        checks++;
        if (ifid_instr !== 16'h2002 || ifid_pcplus2 !== 16'h0004 || imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            failures++;
            $display("FAIL stall_wait got instr=%h pc2=%h req=%b addr=%h exp 2002/0004/1/0004",
                     ifid_instr, ifid_pcplus2, imem_req, imem_addr);
        end
        tick(1);
        checks++;
        if (ifid_instr !== 16'h2002 || ifid_pcplus2 !== 16'h0004 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold got instr=%h pc2=%h req=%b exp 2002/0004/0",
                     ifid_instr, ifid_pcplus2, imem_req);
        end
        tick(1);
        checks++;
        if (ifid_instr !== 16'h2002 || ifid_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold2 got instr=%h v=%b req=%b exp 2002/1/0", ifid_instr, ifid_valid, imem_req);
        end
        stall = 1'b0;
        tick(1);
        checks++;
        if (ifid_instr !== 16'h4004 || ifid_pcplus2 !== 16'h0006 || imem_addr !== 16'h0006 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got instr=%h pc2=%h addr=%h req=%b exp 4004/0006/0006/1",
                     ifid_instr, ifid_pcplus2, imem_addr, imem_req);
        end
        $display("tb: skid word %h delivered pc2=%h", ifid_instr, ifid_pcplus2);
    endtask

    task automatic test_redirect();
        tick(2);
        memLatency = 3;
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        tick(1);
        redirect = 1'b0;
        checks++;
        if (ifid_instr !== 16'h0000 || ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
            failures++;
            $display("FAIL redirect_flush got instr=%h v=%b req=%b addr=%h exp 0000/0/1/0008",
                     ifid_instr, ifid_valid, imem_req, imem_addr);
        end
        tick(2);
        checks++;
        if (imem_addr !== 16'h0040 || imem_req !== 1'b1 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000) begin
            failures++;
            $display("FAIL redirect_drop got addr=%h req=%b v=%b instr=%h exp 0040/1/0/0000",
                     imem_addr, imem_req, ifid_valid, ifid_instr);
        end
        tick(4);
        checks++;
        if (ifid_instr !== 16'h0A40 || ifid_pcplus2 !== 16'h0042 || ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target got instr=%h pc2=%h v=%b exp 0A40/0042/1",
                     ifid_instr, ifid_pcplus2, ifid_valid);
        end
        $display("tb: redirect target fetched %h pc2=%h", ifid_instr, ifid_pcplus2);
        memLatency = 1;
    endtask

    task automatic test_redirect_stall();
        tick(1);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick(1);
        stall    = 1'b0;
        redirect = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || imem_addr !== 16'h0100 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL redir_stall got v=%b instr=%h addr=%h req=%b exp 0/0000/0100/1",
                     ifid_valid, ifid_instr, imem_addr, imem_req);
        end
        tick(2);
        checks++;
        if (ifid_instr !== 16'h0B00 || ifid_pcplus2 !== 16'h0102 || imem_addr !== 16'h0102) begin
            failures++;
            $display("FAIL redir_stall_next got instr=%h pc2=%h addr=%h exp 0B00/0102/0102",
                     ifid_instr, ifid_pcplus2, imem_addr);
        end
        $display("tb: redirect beat stall, fetched %h", ifid_instr);
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick(1);
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 16'h0102 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_drop got addr=%h req=%b v=%b exp 0102/1/0", imem_addr, imem_req, ifid_valid);
        end
        tick(1);
        checks++;
        if (imem_addr !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_addr got addr=%h exp fffe", imem_addr);
        end
        tick(2);
        checks++;
        if (ifid_instr !== 16'h3FFF || ifid_pcplus2 !== 16'h0000 || ifid_valid !== 1'b1 || imem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_fetch got instr=%h pc2=%h v=%b addr=%h exp 3fff/0000/1/0000",
                     ifid_instr, ifid_pcplus2, ifid_valid, imem_addr);
        end
        $display("tb: wrap fetch %h pc2=%h", ifid_instr, ifid_pcplus2);
    endtask

    task automatic test_reset_in_drop();
        tick(2);
        memLatency = 3;
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick(1);
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 16'h0002 || imem_req !== 1'b1 || ifid_valid !== 1'b0 || ifid_pcplus2 !== 16'h0002) begin
            failures++;
            $display("FAIL drop_before_reset got addr=%h req=%b v=%b pc2=%h exp 0002/1/0/0002",
                     imem_addr, imem_req, ifid_valid, ifid_pcplus2);
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || ifid_instr !== 16'h0000 ||
            ifid_pcplus2 !== 16'h0000 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_drop got req=%b addr=%h instr=%h pc2=%h v=%b exp 0/0000/0000/0000/0",
                     imem_req, imem_addr, ifid_instr, ifid_pcplus2, ifid_valid);
        end
        memLatency = 1;
        reset = 1'b1;
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL restart_req got req=%b addr=%h exp 1/0000", imem_req, imem_addr);
        end
        tick(2);
        checks++;
        if (ifid_instr !== 16'h0001 || ifid_pcplus2 !== 16'h0002 || imem_addr !== 16'h0002) begin
            failures++;
            $display("FAIL restart_fetch got instr=%h pc2=%h addr=%h exp 0001/0002/0002",
                     ifid_instr, ifid_pcplus2, imem_addr);
        end
        $display("tb: restart after reset fetched %h", ifid_instr);
    endtask

    task automatic test_jump_predecode();
        logic [15:0] expAddr;
`ifdef FETCH_JUMP_PREDECODE_EN
        expAddr = 16'h000A;
`else
        expAddr = 16'h0002;
`endif
        memImg[0] = 16'hE005;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        checks++;
        if (ifid_instr !== 16'hE005 || ifid_pcplus2 !== 16'h0002 || ifid_valid !== 1'b1 || imem_addr !== expAddr) begin
            failures++;
            $display("FAIL jump_fetch got instr=%h pc2=%h v=%b addr=%h exp e005/0002/1/%h",
                     ifid_instr, ifid_pcplus2, ifid_valid, imem_addr, expAddr);
        end
        $display("tb: jump word fetched, next addr %h", imem_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            logic [15:0] idx;
            idx       = 16'(i);
            memImg[i] = {3'b001, idx[12:0]};
        end
        memImg[0]     = 16'h0001;
        memImg[1]     = 16'h2002;
        memImg[2]     = 16'h4004;
        memImg[16'h20] = 16'h0A40;
        memImg[16'h80] = 16'h0B00;
        memLatency  = 1;
        memPending  = 1'b0;
        memCnt      = 0;
        memAddr     = 16'h0000;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_in_drop();
        test_jump_predecode();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
